// File: rtl/rgu_data_ram_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter: arbitration states and
// default widths/limits.
package rgu_data_ram_arbiter_pkg;

  localparam int GPU_WORD             = 32;
  localparam int RGU_ARB_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CORE_LOCK  = 2'd1,
    ST_UART_FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rgu_sat_counter.sv
// Saturating up-counter that tracks how long the UART has waited;
// oSat flags that the wait has reached LIMIT.
module rgu_sat_counter
  import rgu_data_ram_arbiter_pkg::*;
#(
  parameter int LIMIT = RGU_ARB_STARVE_LIMIT,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic iClock,
  input  logic iReset,
  input  logic iInc,
  input  logic iClr,
  output logic oSat
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_count <= '0;
    end else if (iClr) begin
      r_count <= '0;
    end else if (iInc && (r_count != LIMIT_V)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign oSat = (r_count == LIMIT_V);

endmodule

// File: rtl/rgu_data_ram_arbiter.sv
// Single-port data RAM arbiter between the core and the UART loader, with
// core lock ownership and a starvation-forced UART slot.
module rgu_data_ram_arbiter
  import rgu_data_ram_arbiter_pkg::*;
#(
  parameter int DATA_W       = GPU_WORD,
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = RGU_ARB_STARVE_LIMIT
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iCoreReq,
  input  logic              iCoreWrite,
  input  logic              iCoreLock,
  input  logic [ADDR_W-1:0] iCoreAddr,
  input  logic [DATA_W-1:0] iCoreData,
  output logic              oCoreGrant,
  output logic              oCoreValid,
  output logic [DATA_W-1:0] oCoreData,
  input  logic              iUartSelected,
  input  logic              iUartWrite,
  input  logic [ADDR_W-1:0] iUartAddr,
  input  logic [DATA_W-1:0] iUartData,
  output logic              oUartGrant,
  output logic              oUartValid,
  output logic [DATA_W-1:0] oUartData,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic              oRamWe,
  output logic [DATA_W-1:0] oRamData,
  input  logic [DATA_W-1:0] iRamData
);

  arb_state_e        r_state, w_next_state;
  logic              w_core_grant, w_uart_grant, w_starved;
  logic              r_core_rd, r_uart_rd;
  logic [DATA_W-1:0] r_core_data, r_uart_data;

  rgu_sat_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .iClock (iClock),
    .iReset (iReset),
    .iInc   (iUartSelected && !w_uart_grant),
    .iClr   (!iUartSelected || w_uart_grant),
    .oSat   (w_starved)
  );

  // NOTE: every signal gets a default at the top of always_comb so no
  // path through the case can infer a latch.
  always_comb begin
    w_core_grant = 1'b0;
    w_uart_grant = 1'b0;
    w_next_state = r_state;
    if (!iReset) begin
      case (r_state)
        ST_IDLE: begin
          if (iCoreReq)           w_core_grant = 1'b1;
          else if (iUartSelected) w_uart_grant = 1'b1;
          // A starved UART that still lost this cycle takes the next one.
          if (w_starved && !w_uart_grant)        w_next_state = ST_UART_FORCE;
          else if (w_core_grant && iCoreLock)    w_next_state = ST_CORE_LOCK;
        end
        ST_CORE_LOCK: begin
          w_core_grant = iCoreReq;
          if (!iCoreLock) w_next_state = ST_IDLE;
        end
        ST_UART_FORCE: begin
          w_uart_grant = iUartSelected;
          w_next_state = ST_IDLE;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state     <= ST_IDLE;
      r_core_rd   <= 1'b0;
      r_uart_rd   <= 1'b0;
      r_core_data <= '0;
      r_uart_data <= '0;
    end else begin
      r_state   <= w_next_state;
      r_core_rd <= w_core_grant && !iCoreWrite;
      r_uart_rd <= w_uart_grant && !iUartWrite;
      if (r_core_rd) r_core_data <= iRamData;
      if (r_uart_rd) r_uart_data <= iRamData;
    end
  end

  assign oCoreGrant = w_core_grant;
  assign oUartGrant = w_uart_grant;

  // Read data is forwarded in its valid cycle; reset masks a pending pulse.
  assign oCoreValid = r_core_rd && !iReset;
  assign oUartValid = r_uart_rd && !iReset;
  assign oCoreData  = iReset ? '0 : (r_core_rd ? iRamData : r_core_data);
  assign oUartData  = iReset ? '0 : (r_uart_rd ? iRamData : r_uart_data);

  assign oRamAddr = w_core_grant ? iCoreAddr  : (w_uart_grant ? iUartAddr  : '0);
  assign oRamData = w_core_grant ? iCoreData  : (w_uart_grant ? iUartData  : '0);
  assign oRamWe   = w_core_grant ? iCoreWrite : (w_uart_grant && iUartWrite);

endmodule

// File: tb/tb_rgu_data_ram_arbiter.sv
// Self-checking bench for rgu_data_ram_arbiter: single-cycle arbitration
// vectors plus directed multi-cycle sequences against a small RAM model.
module tb_rgu_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_wr, core_lock;
  logic [7:0]  core_addr;
  logic [31:0] core_data;
  logic        uart_req, uart_wr;
  logic [7:0]  uart_addr;
  logic [31:0] uart_data;
  logic        core_grant, core_valid, uart_grant, uart_valid, ram_we;
  logic [31:0] core_rdata, uart_rdata, ram_wdata, ram_q;
  logic [7:0]  ram_addr;
  logic [31:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rgu_data_ram_arbiter dut (
    .iClock        (clk),
    .iReset        (rst),
    .iCoreReq      (core_req),
    .iCoreWrite    (core_wr),
    .iCoreLock     (core_lock),
    .iCoreAddr     (core_addr),
    .iCoreData     (core_data),
    .oCoreGrant    (core_grant),
    .oCoreValid    (core_valid),
    .oCoreData     (core_rdata),
    .iUartSelected (uart_req),
    .iUartWrite    (uart_wr),
    .iUartAddr     (uart_addr),
    .iUartData     (uart_data),
    .oUartGrant    (uart_grant),
    .oUartValid    (uart_valid),
    .oUartData     (uart_rdata),
    .oRamAddr      (ram_addr),
    .oRamWe        (ram_we),
    .oRamData      (ram_wdata),
    .iRamData      (ram_q)
  );

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  typedef struct {
    logic        creq, cwr;
    logic [7:0]  caddr;
    logic [31:0] cdata;
    logic        ureq, uwr;
    logic [7:0]  uaddr;
    logic [31:0] udata;
    logic        exp_cg, exp_ug, exp_we;
    logic [7:0]  exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then let outputs settle.
  task automatic drive(input logic r, input logic creq, input logic cwr, input logic clock_l,
                       input logic [7:0] caddr, input logic [31:0] cdata,
                       input logic ureq, input logic uwr, input logic [7:0] uaddr,
                       input logic [31:0] udata);
    @(posedge clk);
    #1;
    rst = r; core_req = creq; core_wr = cwr; core_lock = clock_l;
    core_addr = caddr; core_data = cdata;
    uart_req = ureq; uart_wr = uwr; uart_addr = uaddr; uart_data = udata;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    rst = 1'b1; core_req = 0; core_wr = 0; core_lock = 0; core_addr = '0; core_data = '0;
    uart_req = 0; uart_wr = 0; uart_addr = '0; uart_data = '0;

    //            creq cwr caddr  cdata         ureq uwr uaddr  udata         cg ug we addr   wdata
    vecs[0] = '{0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0};
    vecs[1] = '{1, 0, 8'h05, 32'h0,        0, 0, 8'h00, 32'h0,        1, 0, 0, 8'h05, 32'h0};
    vecs[2] = '{1, 1, 8'h07, 32'h0000AAAA, 0, 0, 8'h00, 32'h0,        1, 0, 1, 8'h07, 32'h0000AAAA};
    vecs[3] = '{0, 0, 8'h00, 32'h0,        1, 0, 8'h09, 32'h0,        0, 1, 0, 8'h09, 32'h0};
    vecs[4] = '{0, 0, 8'h00, 32'h0,        1, 1, 8'hFF, 32'h00005555, 0, 1, 1, 8'hFF, 32'h00005555};
    vecs[5] = '{1, 1, 8'h02, 32'h00001111, 1, 1, 8'h03, 32'h00002222, 1, 0, 1, 8'h02, 32'h00001111};
    vecs[6] = '{1, 0, 8'h10, 32'h0,        1, 1, 8'h11, 32'h00003333, 1, 0, 0, 8'h10, 32'h0};

    // Each vector: a reset cycle (requests present but nothing granted),
    // then the vector itself from a clean IDLE state.
    for (int i = 0; i < 7; i++) begin
      drive(1, vecs[i].creq, vecs[i].cwr, 0, vecs[i].caddr, vecs[i].cdata,
            vecs[i].ureq, vecs[i].uwr, vecs[i].uaddr, vecs[i].udata);
      check($sformatf("rst%0d_grants", i), {core_grant, uart_grant, ram_we}, 3'b000);
      check($sformatf("rst%0d_valids", i), {core_valid, uart_valid}, 2'b00);
      check($sformatf("rst%0d_rdata", i), {core_rdata, uart_rdata}, 64'h0);
      drive(0, vecs[i].creq, vecs[i].cwr, 0, vecs[i].caddr, vecs[i].cdata,
            vecs[i].ureq, vecs[i].uwr, vecs[i].uaddr, vecs[i].udata);
      check($sformatf("vec%0d_grants", i), {core_grant, uart_grant},
            {vecs[i].exp_cg, vecs[i].exp_ug});
      check($sformatf("vec%0d_we", i), ram_we, vecs[i].exp_we);
      check($sformatf("vec%0d_addr", i), ram_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_wdata", i), ram_wdata, vecs[i].exp_wdata);
    end

    // Simultaneous reads: core first, UART next cycle, data forwarded.
    drive(1, 0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    drive(0, 1, 1, 0, 8'h03, 32'h00020000, 0, 0, 8'h00, 32'h0);
    check("preload_core_wr", {core_grant, ram_we}, 2'b11);
    drive(0, 0, 0, 0, 8'h00, 32'h0, 1, 1, 8'h04, 32'h00000044);
    check("preload_uart_wr", {uart_grant, ram_we}, 2'b11);
    drive(0, 1, 0, 0, 8'h03, 32'h0, 1, 0, 8'h04, 32'h0);
    check("sim_c0_grants", {core_grant, uart_grant}, 2'b10);
    check("sim_c0_addr", ram_addr, 8'h03);
    drive(0, 0, 0, 0, 8'h00, 32'h0, 1, 0, 8'h04, 32'h0);
    check("sim_c1_core_valid", core_valid, 1'b1);
    check("sim_c1_core_data", core_rdata, 32'h00020000);
    check("sim_c1_uart_grant", {core_grant, uart_grant}, 2'b01);
    check("sim_c1_addr", ram_addr, 8'h04);
    idle();
    check("sim_c2_uart_valid", {uart_valid, uart_rdata}, {1'b1, 32'h00000044});
    check("sim_c2_core_hold", {core_valid, core_rdata}, {1'b0, 32'h00020000});
    idle();
    check("sim_c3_uart_hold", {uart_valid, uart_rdata}, {1'b0, 32'h00000044});

    // UART write then core read of the same word; writes give no valid.
    drive(0, 0, 0, 0, 8'h00, 32'h0, 1, 1, 8'h01, 32'h00040000);
    check("uwr_grant_we", {uart_grant, ram_we}, 2'b11);
    drive(0, 1, 0, 0, 8'h01, 32'h0, 0, 0, 8'h00, 32'h0);
    check("crd_grant", {core_grant, ram_we}, 2'b10);
    check("uwr_no_valid", uart_valid, 1'b0);
    idle();
    check("crd_data", {core_valid, core_rdata}, {1'b1, 32'h00040000});
    check("crd_no_uart_valid", uart_valid, 1'b0);

    // Reset the cycle after a granted read, with the starve counter non-zero.
    drive(0, 1, 0, 0, 8'h03, 32'h0, 1, 0, 8'h06, 32'h0);
    check("pre_rst_core_grant", core_grant, 1'b1);
    drive(1, 1, 0, 0, 8'h03, 32'h0, 1, 0, 8'h06, 32'h0);
    check("rst_drops_valid", {core_valid, core_rdata}, 33'h0);
    check("rst_no_grant", {core_grant, uart_grant}, 2'b00);

    // Starvation: counter restarted by reset, so UART is forced on cycle 9.
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 0, 0, 8'(k), 32'h0, 1, 0, 8'h06, 32'h0);
      check($sformatf("starve_c%0d", k), {core_grant, uart_grant},
            (k == 9) ? 2'b01 : 2'b10);
    end
    idle();
    check("starve_uart_valid", {uart_valid, uart_rdata}, {1'b1, 32'h0});
    check("starve_core_stalled", core_valid, 1'b0);

    // Lock for 20 cycles with UART pending; UART granted right after release.
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 0, (k < 19) ? 1'b1 : 1'b0, 8'(k), 32'h0, 1, 0, 8'h06, 32'h0);
      check($sformatf("lock_c%0d", k), {core_grant, uart_grant}, 2'b10);
    end
    drive(0, 0, 0, 0, 8'h00, 32'h0, 1, 0, 8'h06, 32'h0);
    check("lock_release_uart", {core_grant, uart_grant}, 2'b01);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgu_data_ram_arbiter.md
RGU_DATA_RAM_ARBITER -- requirements
Module: rgu_data_ram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32 (`GPU_WORD), the data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 8, the data RAM address width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 8, the maximum number of consecutive cycles a UART request may wait.
REQ-004 iClock  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 iReset  in  1  synchronous, active-high reset.
REQ-006 iCoreReq  in  1  core requests one RAM access this cycle.
REQ-007 iCoreWrite  in  1  1 = write, 0 = read.
REQ-008 iCoreLock  in  1  core asks to keep ownership on following cycles.
REQ-009 iCoreAddr  in  ADDR_W  core address.
REQ-010 iCoreData  in  DATA_W  core write data.
REQ-011 oCoreGrant  out  1  core access performed this cycle.
REQ-012 oCoreValid  out  1  core read data valid.
REQ-013 oCoreData  out  DATA_W  core read data.
REQ-014 iUartSelected  in  1  UART request.
REQ-015 iUartWrite  in  1  UART write strobe.
REQ-016 iUartAddr  in  ADDR_W  UART address.
REQ-017 iUartData  in  DATA_W  UART write data.
REQ-018 oUartGrant  out  1  UART access performed this cycle.
REQ-019 oUartValid  out  1  UART read data valid.
REQ-020 oUartData  out  DATA_W  UART read data.
REQ-021 oRamAddr  out  ADDR_W, oRamWe out 1, oRamData out DATA_W  single-port RAM strobes.
REQ-022 iRamData  in  DATA_W  RAM read data, one cycle after address.

Function
REQ-023 FSM states: IDLE, CORE_LOCK, UART_FORCE.
REQ-024 Arbitration is combinational within the cycle: at most one of oCoreGrant and oUartGrant SHALL be high; the RAM strobes are driven from the winner in the same cycle.
REQ-025 IDLE: a core request wins over a simultaneous UART request; a lone request of either kind is granted.
REQ-026 IDLE with granted iCoreReq and iCoreLock high -> CORE_LOCK next cycle.
REQ-027 CORE_LOCK: only the core is granted; UART is blocked; exit to IDLE on the first cycle with iCoreLock low (that cycle still belongs to the core).
REQ-028 Starve counter: increments, saturating at STARVE_LIMIT, on every cycle iUartSelected is high and oUartGrant is low; clears on a UART grant or when iUartSelected is low.
REQ-029 When the counter equals STARVE_LIMIT in IDLE -> UART_FORCE; UART_FORCE grants UART exactly one cycle regardless of core requests, then returns to IDLE.
REQ-030 A lock in progress is never broken; the counter holds at STARVE_LIMIT, and the forced grant occurs on the first IDLE cycle after the lock releases.
REQ-031 Read latency: oXValid SHALL pulse exactly one cycle after a granted read (iXWrite low), with oXData = iRamData; oXData holds its last value otherwise.
REQ-032 Writes produce no valid pulse; oRamWe = granted requester's write bit; oRamWe = 0 when nothing is granted.
REQ-033 A request withdrawn before grant SHALL leave no side effects; requesters must hold request and operands until granted.

Reset
REQ-034 Reset SHALL set the state to IDLE, the counter to 0, and every output to 0, and SHALL drop a pending read-valid pulse.
REQ-035 Asserting reset mid-lock or mid-force SHALL abandon the transaction; no grant is issued during a reset cycle.

Structure
REQ-036 The state encodings and the RGU_ARB_STARVE_LIMIT default SHALL live in Definitions.v.
REQ-037 The saturating starve counter SHALL be one sub-module, rgu_sat_counter; everything else SHALL stay inline.

Verification
REQ-038 Simultaneous core read addr 3 and UART read addr 4 with RAM[3]=32'h20000 -> oCoreGrant cycle 0, oCoreValid and data 32'h20000 cycle 1; UART granted in cycle 1.
REQ-039 Continuous core requests with UART held high, STARVE_LIMIT=8 -> UART granted exactly on cycle 9, core stalled that cycle.
REQ-040 Core lock for 20 cycles with UART pending -> no UART grant during the lock; UART granted on the first cycle after lock release.
REQ-041 UART write addr 1 data 32'h40000 followed by core read addr 1 -> oCoreData = 32'h40000, no oUartValid pulse.
REQ-042 Reset asserted the cycle after a granted read -> oCoreValid stays 0, state IDLE, counter 0.
